// File: rtl/bilinear_seq_engine.sv
// Bilinear down-scaler: reads a W x H 8-bit image from mem_in, writes the
// scaled image to mem_out, one output pixel every 8 cycles.
// Ports:
//   clk_sys, rst_sys_n            clock, async active-low reset
//   start_pulse, cfg_in_w/h,
//   cfg_scale_q88                 job request + config from the bridge
//   status_done/busy, perf_*      status and perf counters to the bridge
//   in_mem_raddr/rdata            mem_in port (1-cycle read latency)
//   out_mem_waddr/wdata/we        mem_out write port
module bilinear_seq_engine #(
  parameter int AW = 12
) (
  input  logic          clk_sys,
  input  logic          rst_sys_n,
  input  logic          start_pulse,
  input  logic [15:0]   cfg_in_w,
  input  logic [15:0]   cfg_in_h,
  input  logic [15:0]   cfg_scale_q88,
  output logic          status_done,
  output logic          status_busy,
  output logic [31:0]   perf_flops,
  output logic [31:0]   perf_mem_rd,
  output logic [31:0]   perf_mem_wr,
  output logic [AW-1:0] in_mem_raddr,
  input  logic [7:0]    in_mem_rdata,
  output logic [AW-1:0] out_mem_waddr,
  output logic [7:0]    out_mem_wdata,
  output logic          out_mem_we
);

  typedef enum logic [3:0] {
    S_IDLE, S_DIV, S_SETUP,
    S_RA, S_RB, S_RC, S_RD,
    S_CAP, S_HOR, S_VER, S_WR,
    S_DONE
  } state_e;

  localparam logic [AW-1:0] PIX_ONE = 1;

  state_e        state_q, state_d;
  logic          start_prev_q;
  logic [15:0]   w_q, w_d, h_q, h_d, s_q, s_d;
  logic [16:0]   rem_q, rem_d, inv_q, inv_d;
  logic [4:0]    div_cnt_q, div_cnt_d;
  logic [23:0]   ow_q, ow_d, oh_q, oh_d;
  logic [23:0]   ox_q, ox_d, oy_q, oy_d;
  logic [31:0]   sx_q, sx_d, sy_q, sy_d;
  logic [7:0]    p00_q, p00_d, p01_q, p01_d;
  logic [7:0]    p10_q, p10_d, p11_q, p11_d;
  logic [16:0]   t_q, t_d, b_q, b_d;
  logic [7:0]    o_q, o_d;
  logic [AW-1:0] pix_q, pix_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [31:0]   flops_q, flops_d;
  logic [31:0]   rd_q, rd_d, wr_q, wr_d;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [3:0]  inc
  );
    logic [32:0] s;
    s = {1'b0, a} + {29'd0, inc};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // source coordinates, clamped to the last column/row
  logic [15:0] w_m1, h_m1;
  logic [15:0] x0, x1, y0, y1;
  logic [7:0]  fx, fy;
  logic [8:0]  fx_c, fy_c;

  assign w_m1 = w_q - 16'd1;
  assign h_m1 = h_q - 16'd1;
  assign x0 = (sx_q[31:8] > {8'd0, w_m1}) ?
              w_m1 : sx_q[23:8];
  assign y0 = (sy_q[31:8] > {8'd0, h_m1}) ?
              h_m1 : sy_q[23:8];
  assign x1 = (x0 < w_m1) ? x0 + 16'd1 : w_m1;
  assign y1 = (y0 < h_m1) ? y0 + 16'd1 : h_m1;
  assign fx = sx_q[7:0];
  assign fy = sy_q[7:0];
  assign fx_c = 9'd256 - {1'b0, fx};
  assign fy_c = 9'd256 - {1'b0, fy};

  // read address mux: RA p00, RB p01, RC p10, RD p11
  logic [15:0] rd_x, rd_y;
  logic [31:0] addr_full;
  logic        rd_phase;

  always_comb begin
    rd_x = x0;
    rd_y = y0;
    unique case (state_q)
      S_RB: rd_x = x1;
      S_RC: rd_y = y1;
      S_RD: begin
        rd_x = x1;
        rd_y = y1;
      end
      default: ;
    endcase
  end

  assign addr_full = {16'd0, rd_y} * {16'd0, w_q}
                   + {16'd0, rd_x};
  assign rd_phase = (state_q == S_RA) || (state_q == S_RB)
                 || (state_q == S_RC) || (state_q == S_RD);

  // datapath
  logic [16:0] hor_t, hor_b;
  logic [25:0] ver_sum;
  logic [31:0] w_s, h_s;
  logic [23:0] ow_raw, oh_raw;
  logic [17:0] div_sh, div_diff;
  logic        div_ge;

  assign hor_t = {9'd0, p00_q} * {8'd0, fx_c}
               + {9'd0, p01_q} * {9'd0, fx};
  assign hor_b = {9'd0, p10_q} * {8'd0, fx_c}
               + {9'd0, p11_q} * {9'd0, fx};
  assign ver_sum = {9'd0, t_q} * {17'd0, fy_c}
                 + {9'd0, b_q} * {18'd0, fy}
                 + 26'd32768;
  assign w_s = {16'd0, w_q} * {16'd0, s_q};
  assign h_s = {16'd0, h_q} * {16'd0, s_q};
  assign ow_raw = w_s[31:8];
  assign oh_raw = h_s[31:8];

  // restoring divide of 0x10000: the dividend's only set bit enters first
  assign div_sh = {rem_q, div_cnt_q == 5'd0};
  assign div_diff = div_sh - {2'b00, s_q};
  assign div_ge = div_sh >= {2'b00, s_q};

  logic unused_bits;
  assign unused_bits = ^{addr_full[31:AW], w_s[7:0],
                         h_s[7:0], ver_sum[15:0],
                         div_diff[17]};

  logic accept;
  assign accept = start_pulse && !start_prev_q &&
                  (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    s_d       = s_q;
    rem_d     = rem_q;
    inv_d     = inv_q;
    div_cnt_d = div_cnt_q;
    ow_d      = ow_q;
    oh_d      = oh_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    p00_d     = p00_q;
    p01_d     = p01_q;
    p10_d     = p10_q;
    p11_d     = p11_q;
    t_d       = t_q;
    b_d       = b_q;
    o_d       = o_q;
    pix_d     = pix_q;
    busy_d    = busy_q;
    done_d    = done_q;
    flops_d   = flops_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d   = S_DIV;
          w_d       = cfg_in_w;
          h_d       = cfg_in_h;
          s_d       = (cfg_scale_q88 == 16'd0) ?
                      16'd256 : cfg_scale_q88;
          rem_d     = '0;
          inv_d     = '0;
          div_cnt_d = '0;
          flops_d   = '0;
          rd_d      = '0;
          wr_d      = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
        end
      end
      S_DIV: begin
        rem_d = div_ge ? div_diff[16:0] : div_sh[16:0];
        inv_d = {inv_q[15:0], div_ge};
        div_cnt_d = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'd16) state_d = S_SETUP;
      end
      S_SETUP: begin
        ow_d  = (ow_raw == 24'd0) ? 24'd1 : ow_raw;
        oh_d  = (oh_raw == 24'd0) ? 24'd1 : oh_raw;
        sx_d  = '0;
        sy_d  = '0;
        ox_d  = '0;
        oy_d  = '0;
        pix_d = '0;
        if (w_q == 16'd0 || h_q == 16'd0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_RA;
        end
      end
      S_RA: state_d = S_RB;
      S_RB: begin
        p00_d   = in_mem_rdata;
        state_d = S_RC;
      end
      S_RC: begin
        p01_d   = in_mem_rdata;
        state_d = S_RD;
      end
      S_RD: begin
        p10_d   = in_mem_rdata;
        state_d = S_CAP;
      end
      S_CAP: begin
        p11_d   = in_mem_rdata;
        state_d = S_HOR;
      end
      S_HOR: begin
        t_d     = hor_t;
        b_d     = hor_b;
        state_d = S_VER;
      end
      S_VER: begin
        o_d = (ver_sum[25:24] != 2'd0) ?
              8'hFF : ver_sum[23:16];
        state_d = S_WR;
      end
      S_WR: begin
        flops_d = sat_add(flops_q, 4'd9);
        rd_d    = sat_add(rd_q, 4'd4);
        wr_d    = sat_add(wr_q, 4'd1);
        pix_d   = pix_q + PIX_ONE;
        if (ox_q < ow_q - 24'd1) begin
          ox_d    = ox_q + 24'd1;
          sx_d    = sx_q + {15'd0, inv_q};
          state_d = S_RA;
        end else if (oy_q < oh_q - 24'd1) begin
          ox_d    = '0;
          sx_d    = '0;
          oy_d    = oy_q + 24'd1;
          sy_d    = sy_q + {15'd0, inv_q};
          state_d = S_RA;
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      w_q          <= '0;
      h_q          <= '0;
      s_q          <= '0;
      rem_q        <= '0;
      inv_q        <= '0;
      div_cnt_q    <= '0;
      ow_q         <= '0;
      oh_q         <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      p00_q        <= '0;
      p01_q        <= '0;
      p10_q        <= '0;
      p11_q        <= '0;
      t_q          <= '0;
      b_q          <= '0;
      o_q          <= '0;
      pix_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      flops_q      <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_pulse;
      w_q          <= w_d;
      h_q          <= h_d;
      s_q          <= s_d;
      rem_q        <= rem_d;
      inv_q        <= inv_d;
      div_cnt_q    <= div_cnt_d;
      ow_q         <= ow_d;
      oh_q         <= oh_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      p00_q        <= p00_d;
      p01_q        <= p01_d;
      p10_q        <= p10_d;
      p11_q        <= p11_d;
      t_q          <= t_d;
      b_q          <= b_d;
      o_q          <= o_d;
      pix_q        <= pix_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      flops_q      <= flops_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end

  assign status_done   = done_q;
  assign status_busy   = busy_q;
  assign perf_flops    = flops_q;
  assign perf_mem_rd   = rd_q;
  assign perf_mem_wr   = wr_q;
  assign in_mem_raddr  = rd_phase ? addr_full[AW-1:0] : '0;
  assign out_mem_we    = (state_q == S_WR);
  assign out_mem_waddr = out_mem_we ? pix_q : '0;
  assign out_mem_wdata = out_mem_we ? o_q : '0;

endmodule
